// File: rtl/arb_rx_fifo.sv
// Clocked receiver for the arbiter-tree output: 4-phase req/ack in, FIFO, valid/ready out.
// Optional source-id check enabled by defining SRC_CHECK_EN.
module arb_rx_fifo #(
    parameter int WIDTH       = 18,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     l_req,
    input  logic [WIDTH-1:0]         l_data,
    output logic                     l_ack,
    output logic                     r_valid,
    output logic [WIDTH-1:0]         r_data,
    input  logic                     r_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_drop
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] sync;
    logic                req_s;
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                full;
    logic                empty;
    logic                src_ok;
    logic                take;
    logic                push;
    logic                pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], l_req};
    end
    assign req_s = sync[SYNC_STAGES-1];

`ifdef SRC_CHECK_EN
    assign src_ok = (l_data[WIDTH-1 -: 4] <= 4'd13);
`else
    assign src_ok = 1'b1;
`endif

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Invalid-id packets are acked and discarded, so they bypass the full check.
    assign take  = (state == IDLE) && req_s && (!full || !src_ok);
    assign push  = take && src_ok;
    assign pop   = !empty && r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            l_ack    <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= take && !src_ok;
            case (state)
                IDLE: if (take) begin
                    l_ack <= 1'b1;
                    state <= ACK;
                end
                ACK: if (!req_s) begin
                    l_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= l_data;
    end

    assign r_data  = mem[rd_ptr[AW-1:0]];
    assign r_valid = !empty;
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_arb_rx_fifo.sv
// Scoreboard bench for arb_rx_fifo: upstream 4-phase driver, queue reference model, monitor.
module tb_arb_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l_req = 1'b0;
    logic [17:0] l_data = '0;
    logic        l_ack;
    logic        r_valid;
    logic [17:0] r_data;
    logic        r_ready = 1'b0;
    logic [2:0]  count;
    logic        err_drop;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    arb_rx_fifo #(.WIDTH(18), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .l_req(l_req), .l_data(l_data), .l_ack(l_ack),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready), .count(count),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic bit keep(input logic [17:0] d);
`ifdef SRC_CHECK_EN
        return d[17:14] <= 4'd13;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted output beat must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", r_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (r_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", r_data, e, $time);
                end
            end
        end
    end

    task automatic wait_ack(input logic val, output int edges);
        edges = 0;
        while (l_ack !== val && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
        if (l_ack !== val) begin
            total++; bad++;
            $display("FAIL ack_timeout: got %0b expected %0b", l_ack, val);
        end
    endtask

    task automatic send(input logic [17:0] d);
        int e;
        if (keep(d)) exp_q.push_back(d);
        l_data = d;
        l_req  = 1'b1;
        wait_ack(1'b1, e);
        l_req  = 1'b0;
        wait_ack(1'b0, e);
    endtask

    task automatic drain();
        int n = 0;
        r_ready = 1'b1;
        while (count != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        r_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_queue", exp_q.size(), 32'd0);
    endtask

    initial begin
        int  e;
        bit  done;
        logic [17:0] d;

        #2;
        chk("rst_ack", 32'(l_ack), 32'd0);
        chk("rst_valid", 32'(r_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err_drop), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single packet: ack on third edge, show-ahead data, popped next edge.
        r_ready = 1'b1;
        exp_q.push_back(18'h0ABCD);
        l_data = 18'h0ABCD;
        l_req  = 1'b1;
        wait_ack(1'b1, e);
        chk("latency", 32'(e), 32'd3);
        chk("single_valid", 32'(r_valid), 32'd1);
        chk("single_data", 32'(r_data), 32'h0ABCD);
        @(posedge clk); #1;
        chk("single_popped", 32'(count), 32'd0);
        l_req = 1'b0;
        wait_ack(1'b0, e);
        r_ready = 1'b0;

        // Fill to four, then backpressure on the fifth.
        for (int i = 0; i < 4; i++) send(18'(i * 18'h1111 + 18'h00101));
        chk("full_count", 32'(count), 32'd4);
        exp_q.push_back(18'h12345);
        l_data = 18'h12345;
        l_req  = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("held_ack", 32'(l_ack), 32'd0);
        chk("held_count", 32'(count), 32'd4);
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        chk("pop_no_write_count", 32'(count), 32'd3);
        chk("pop_no_write_ack", 32'(l_ack), 32'd0);
        @(posedge clk); #1;
        chk("retry_ack", 32'(l_ack), 32'd1);
        chk("retry_count", 32'(count), 32'd4);
        l_req = 1'b0;
        wait_ack(1'b0, e);
        drain();

        // Ten random packets with r_ready toggling every cycle.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d = 18'($urandom);
                    send(d);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    r_ready = ~r_ready;
                end
            end
        join
        drain();

        // Reset during a handshake with two packets buffered.
        send(18'h0AAAA);
        exp_q.push_back(18'h05555);
        l_data = 18'h05555;
        l_req  = 1'b1;
        wait_ack(1'b1, e);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(l_ack), 32'd0);
        chk("mid_rst_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        exp_q.delete();
        l_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(18'h03C3C);
        chk("restart_count", 32'(count), 32'd1);
        drain();

        // Packet carrying source id 4'hF.
        d = 18'h3C001;
        if (keep(d)) exp_q.push_back(d);
        l_data = d;
        l_req  = 1'b1;
        wait_ack(1'b1, e);
`ifdef SRC_CHECK_EN
        chk("bad_id_err", 32'(err_drop), 32'd1);
        chk("bad_id_count", 32'(count), 32'd0);
`else
        chk("bad_id_err", 32'(err_drop), 32'd0);
        chk("bad_id_count", 32'(count), 32'd1);
`endif
        @(posedge clk); #1;
        chk("bad_id_err_end", 32'(err_drop), 32'd0);
        l_req = 1'b0;
        wait_ack(1'b0, e);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
